// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I main controller: Moore FSM plus immsrc/ALU decoders
module multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    output logic               pcwrite,
    output logic               adrsrc,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regwrite,
    output logic [1:0]         resultsrc,
    output logic [1:0]         alusrca,
    output logic [1:0]         alusrcb,
    output logic [2:0]         immsrc,
    output logic [2:0]         alucontrol,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXECR    = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_EXECI    = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_LUI      = STATE_W'(11);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    logic [STATE_W-1:0] state_q, state_d;
    logic [1:0]         aluop;
    logic               pcupdate, branch;
    logic               memwrite_raw, irwrite_raw, regwrite_raw, illegal_raw;

    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = S_FETCH;
        adrsrc       = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        illegal_raw  = 1'b0;
        resultsrc    = 2'b00;
        alusrca      = 2'b00;
        alusrcb      = 2'b00;
        aluop        = 2'b00;
        pcupdate     = 1'b0;
        branch       = 1'b0;
        case (state_q)
            S_FETCH: begin
                irwrite_raw = 1'b1;
                alusrcb     = 2'b10;
                resultsrc   = 2'b10;
                pcupdate    = 1'b1;
                state_d     = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed here from OldPC + ImmExt
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BR:             state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_LUI:            state_d = S_LUI;
                    default:           illegal_raw = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adrsrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc    = 2'b01;
                regwrite_raw = 1'b1;
            end
            S_MEMWRITE: begin
                adrsrc       = 1'b1;
                memwrite_raw = 1'b1;
            end
            S_EXECR: begin
                alusrca = 2'b10;
                aluop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: regwrite_raw = 1'b1;
            S_BRANCH: begin
                alusrca = 2'b10;
                aluop   = 2'b01;
                branch  = 1'b1;
            end
            S_JAL: begin
                alusrca  = 2'b01;
                alusrcb  = 2'b10;
                pcupdate = 1'b1;
                state_d  = S_ALUWB;
            end
            S_LUI: begin
                resultsrc    = 2'b11;
                regwrite_raw = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE: immsrc = 3'b001;
            OP_BR:    immsrc = 3'b010;
            OP_JAL:   immsrc = 3'b011;
            OP_LUI:   immsrc = 3'b100;
            default:  immsrc = 3'b000;
        endcase
    end

    always_comb begin
        alucontrol = 3'b000;
        if (aluop == 2'b01) begin
            alucontrol = 3'b001;
        end else if (aluop == 2'b10) begin
            case (funct3)
                3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                3'b010:  alucontrol = 3'b101;
                3'b110:  alucontrol = 3'b011;
                3'b111:  alucontrol = 3'b010;
                default: alucontrol = 3'b000;
            endcase
        end
    end

    // funct3[0] inverts the zero test: beq takes on zero, bne on nonzero
    assign pcwrite  = reset & (pcupdate | (branch & (zero ^ funct3[0])));
    assign memwrite = reset & memwrite_raw;
    assign irwrite  = reset & irwrite_raw;
    assign regwrite = reset & regwrite_raw;
    assign illegal  = reset & illegal_raw;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] op = 7'b0000011;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, illegal;
    logic [1:0] resultsrc, alusrca, alusrcb;
    logic [2:0] immsrc, alucontrol;
    logic [3:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [3:0]  st;
        logic [17:0] outs;
    } exp_t;

    exp_t exp_q[$];

    multicycle_ctrl #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .pcwrite(pcwrite), .adrsrc(adrsrc), .memwrite(memwrite), .irwrite(irwrite),
        .regwrite(regwrite), .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb),
        .immsrc(immsrc), .alucontrol(alucontrol), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [17:0] model(input logic [3:0] st, input logic [6:0] o,
                                          input logic [2:0] f3, input logic f7,
                                          input logic z, input logic rst_n);
        logic       pcw, adr, mw, irw, rw, ill;
        logic [1:0] rs, sa, sb;
        logic [2:0] imm, alu, af;
        {pcw, adr, mw, irw, rw, ill} = '0;
        {rs, sa, sb, alu} = '0;
        case (o)
            7'b0100011: imm = 3'd1;
            7'b1100011: imm = 3'd2;
            7'b1101111: imm = 3'd3;
            7'b0110111: imm = 3'd4;
            default:    imm = 3'd0;
        endcase
        case (f3)
            3'd0:    af = (o[5] && f7) ? 3'd1 : 3'd0;
            3'd2:    af = 3'd5;
            3'd6:    af = 3'd3;
            3'd7:    af = 3'd2;
            default: af = 3'd0;
        endcase
        case (st)
            4'd0:  begin irw = 1; sb = 2; rs = 2; pcw = 1; end
            4'd1:  begin
                sa = 1; sb = 1;
                ill = !(o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                                  7'b1100011, 7'b1101111, 7'b0110111});
            end
            4'd2:  begin sa = 2; sb = 1; end
            4'd3:  adr = 1;
            4'd4:  begin rs = 1; rw = 1; end
            4'd5:  begin adr = 1; mw = 1; end
            4'd6:  begin sa = 2; alu = af; end
            4'd7:  begin sa = 2; sb = 1; alu = af; end
            4'd8:  rw = 1;
            4'd9:  begin sa = 2; alu = 3'd1; pcw = f3[0] ? !z : z; end
            4'd10: begin sa = 1; sb = 2; pcw = 1; end
            4'd11: begin rs = 3; rw = 1; end
            default: ;
        endcase
        if (!rst_n) {pcw, mw, irw, rw, ill} = '0;
        return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill};
    endfunction

    // seq holds the expected state codes, one nibble per cycle, first state in the low nibble
    task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic z, input int n,
                             input logic [23:0] seq, input int rst_idx);
        exp_t e;
        for (int i = 0; i < n; i++)
            exp_q.push_back('{st: seq[4*i +: 4], outs: model(seq[4*i +: 4], o, f3, f7, z, i != rst_idx)});
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset    = (i != rst_idx);
            op       = o;
            funct3   = f3;
            funct7b5 = f7;
            zero     = z;
            #1;
            e = exp_q.pop_front();
            check_eq($sformatf("%s c%0d state", name, i), 32'(state), 32'(e.st));
            check_eq($sformatf("%s c%0d outs", name, i),
                     32'({pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc, alusrca,
                          alusrcb, immsrc, alucontrol, illegal}), 32'(e.outs));
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        run_instr("reset",    7'b0000011, 3'd0, 1'b0, 1'b0, 1, 24'h0,      0);
        run_instr("lw",       7'b0000011, 3'd2, 1'b0, 1'b0, 5, 24'h43210,  -1);
        run_instr("sw",       7'b0100011, 3'd2, 1'b0, 1'b0, 4, 24'h5210,   -1);
        run_instr("sub",      7'b0110011, 3'd0, 1'b1, 1'b0, 4, 24'h8610,   -1);
        run_instr("add",      7'b0110011, 3'd0, 1'b0, 1'b0, 4, 24'h8610,   -1);
        run_instr("slt",      7'b0110011, 3'd2, 1'b0, 1'b0, 4, 24'h8610,   -1);
        run_instr("or",       7'b0110011, 3'd6, 1'b0, 1'b0, 4, 24'h8610,   -1);
        run_instr("and",      7'b0110011, 3'd7, 1'b0, 1'b0, 4, 24'h8610,   -1);
        run_instr("addi_f7",  7'b0010011, 3'd0, 1'b1, 1'b0, 4, 24'h8710,   -1);
        run_instr("beq_t",    7'b1100011, 3'd0, 1'b0, 1'b1, 3, 24'h910,    -1);
        run_instr("beq_nt",   7'b1100011, 3'd0, 1'b0, 1'b0, 3, 24'h910,    -1);
        run_instr("bne_t",    7'b1100011, 3'd1, 1'b0, 1'b0, 3, 24'h910,    -1);
        run_instr("bne_nt",   7'b1100011, 3'd1, 1'b0, 1'b1, 3, 24'h910,    -1);
        run_instr("jal",      7'b1101111, 3'd0, 1'b0, 1'b0, 4, 24'h8A10,   -1);
        run_instr("lui",      7'b0110111, 3'd0, 1'b0, 1'b0, 3, 24'hB10,    -1);
        run_instr("illegal",  7'b1111111, 3'd0, 1'b0, 1'b0, 2, 24'h10,     -1);
        run_instr("lui2",     7'b0110111, 3'd0, 1'b0, 1'b0, 3, 24'hB10,    -1);
        run_instr("sw_abort", 7'b0100011, 3'd2, 1'b0, 1'b0, 4, 24'h5210,   3);
        run_instr("lw2",      7'b0000011, 3'd2, 1'b0, 1'b0, 5, 24'h43210,  -1);
        check_eq("scoreboard empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
